// File: rtl/pipeline_readreg_hz.sv
// Decode -> register-read pipeline stage with valid/ready, stall, flush and
// load-use hazard detection over LOAD_STALL stages of load-destination tracking.
module pipeline_readreg_hz #(
  parameter int CTRL_W     = 22,
  parameter int RN_W       = 3,
  parameter int IMM_W      = 16,
  parameter int LOAD_BIT   = 8,
  parameter int LOAD_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [RN_W-1:0]   num_Rm_in,
  input  logic [RN_W-1:0]   num_Rn_in,
  input  logic [RN_W-1:0]   num_Rd_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [2:0]        used_RmRnRd_in,
  input  logic              stall_dn,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] control_out,
  output logic [RN_W-1:0]   num_Rm_out,
  output logic [RN_W-1:0]   num_Rn_out,
  output logic [RN_W-1:0]   num_Rd_out,
  output logic [IMM_W-1:0]  imm_out,
  output logic [2:0]        used_RmRnRd_out,
  output logic              loads,
  output logic              hazard
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] control_q, control_d;
  logic [RN_W-1:0]   rm_q, rm_d;
  logic [RN_W-1:0]   rn_q, rn_d;
  logic [RN_W-1:0]   rd_q, rd_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [2:0]        used_q, used_d;

  logic                  stage_load_v;
  logic [LOAD_STALL-1:0] entry_v;
  logic [RN_W-1:0]       entry_rd [LOAD_STALL];
  logic                  hazard_hit;

  // Entry 0 is the instruction currently sitting in the stage register.
  assign stage_load_v = valid_q & control_q[LOAD_BIT] & used_q[2];

  generate
    if (LOAD_STALL > 1) begin : g_shadow
      // sh_*[i] tracks the instruction i+1 stages further downstream.
      logic [LOAD_STALL-2:0] sh_v_q, sh_v_d;
      logic [RN_W-1:0]       sh_rd_q [LOAD_STALL-1];
      logic [RN_W-1:0]       sh_rd_d [LOAD_STALL-1];

      always_comb begin
        sh_v_d  = sh_v_q;
        sh_rd_d = sh_rd_q;
        if (!stall_dn) begin
          sh_v_d[0]  = stage_load_v;
          sh_rd_d[0] = rd_q;
          for (int k = 1; k < LOAD_STALL - 1; k++) begin
            sh_v_d[k]  = sh_v_q[k-1];
            sh_rd_d[k] = sh_rd_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sh_v_q <= '0;
          for (int k = 0; k < LOAD_STALL - 1; k++) begin
            sh_rd_q[k] <= '0;
          end
        end else begin
          sh_v_q  <= sh_v_d;
          sh_rd_q <= sh_rd_d;
        end
      end

      always_comb begin
        entry_v[0]  = stage_load_v;
        entry_rd[0] = rd_q;
        for (int k = 1; k < LOAD_STALL; k++) begin
          entry_v[k]  = sh_v_q[k-1];
          entry_rd[k] = sh_rd_q[k-1];
        end
      end
    end else begin : g_no_shadow
      always_comb begin
        entry_v[0]  = stage_load_v;
        entry_rd[0] = rd_q;
      end
    end
  endgenerate

  // Only Rm/Rn sources are compared; Rd is a destination, never a source here.
  always_comb begin
    hazard_hit = 1'b0;
    for (int k = 0; k < LOAD_STALL; k++) begin
      if (entry_v[k] &&
          ((used_RmRnRd_in[0] && (num_Rm_in == entry_rd[k])) ||
           (used_RmRnRd_in[1] && (num_Rn_in == entry_rd[k])))) begin
        hazard_hit = 1'b1;
      end
    end
  end

  assign hazard   = in_valid & hazard_hit;
  assign in_ready = !flush & !stall_dn & !hazard;

  always_comb begin
    valid_d   = valid_q;
    control_d = control_q;
    rm_d      = rm_q;
    rn_d      = rn_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    used_d    = used_q;
    if (flush || (!stall_dn && (hazard || !in_valid))) begin
      valid_d   = 1'b0;
      control_d = '0;
      rm_d      = '0;
      rn_d      = '0;
      rd_d      = '0;
      imm_d     = '0;
      used_d    = '0;
    end else if (!stall_dn) begin
      valid_d   = 1'b1;
      control_d = control_in;
      rm_d      = num_Rm_in;
      rn_d      = num_Rn_in;
      rd_d      = num_Rd_in;
      imm_d     = imm_in;
      used_d    = used_RmRnRd_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      control_q <= '0;
      rm_q      <= '0;
      rn_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      used_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      control_q <= control_d;
      rm_q      <= rm_d;
      rn_q      <= rn_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      used_q    <= used_d;
    end
  end

  assign out_valid       = valid_q;
  assign control_out     = control_q;
  assign num_Rm_out      = rm_q;
  assign num_Rn_out      = rn_q;
  assign num_Rd_out      = rd_q;
  assign imm_out         = imm_q;
  assign used_RmRnRd_out = used_q;
  assign loads           = control_q[LOAD_BIT];

endmodule

// File: tb/tb_pipeline_readreg_hz.sv
// Scoreboard bench for pipeline_readreg_hz: one instance with LOAD_STALL=1 and
// one with LOAD_STALL=2 share the stimulus; each test checks one of them.
module tb_pipeline_readreg_hz;

  typedef struct packed {
    logic [21:0] ctrl;
    logic [2:0]  rm;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [15:0] imm;
    logic [2:0]  used;
  } in_t;

  typedef struct packed {
    logic valid;
    in_t  p;
  } out_t;

  typedef struct packed {
    logic v;
    logic st;
    logic fl;
    in_t  in;
    logic exp_haz;
    logic exp_rdy;
    out_t exp;
  } row_t;

  localparam out_t BUBBLE = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        stall_dn = 1'b0;
  logic        flush    = 1'b0;
  logic [21:0] control_in = '0;
  logic [2:0]  num_Rm_in = '0, num_Rn_in = '0, num_Rd_in = '0;
  logic [15:0] imm_in = '0;
  logic [2:0]  used_in = '0;

  logic        rdy1, ov1, loads1, haz1;
  logic [21:0] ctrl1;
  logic [2:0]  rm1, rn1, rd1, used1;
  logic [15:0] imm1;
  logic        rdy2, ov2, loads2, haz2;
  logic [21:0] ctrl2;
  logic [2:0]  rm2, rn2, rd2, used2;
  logic [15:0] imm2;

  out_t obs1, obs2;
  assign obs1 = {ov1, ctrl1, rm1, rn1, rd1, imm1, used1};
  assign obs2 = {ov2, ctrl2, rm2, rn2, rd2, imm2, used2};

  pipeline_readreg_hz #(.LOAD_STALL(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .control_in(control_in), .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in),
    .num_Rd_in(num_Rd_in), .imm_in(imm_in), .used_RmRnRd_in(used_in),
    .stall_dn(stall_dn), .flush(flush), .out_valid(ov1), .control_out(ctrl1),
    .num_Rm_out(rm1), .num_Rn_out(rn1), .num_Rd_out(rd1), .imm_out(imm1),
    .used_RmRnRd_out(used1), .loads(loads1), .hazard(haz1)
  );

  pipeline_readreg_hz #(.LOAD_STALL(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .control_in(control_in), .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in),
    .num_Rd_in(num_Rd_in), .imm_in(imm_in), .used_RmRnRd_in(used_in),
    .stall_dn(stall_dn), .flush(flush), .out_valid(ov2), .control_out(ctrl2),
    .num_Rm_out(rm2), .num_Rn_out(rn2), .num_Rd_out(rd2), .imm_out(imm2),
    .used_RmRnRd_out(used2), .loads(loads2), .hazard(haz2)
  );

  int   errors = 0;
  int   checks = 0;
  int   sel    = 2;
  out_t exp_q[$];

  function automatic in_t mk(input logic [21:0] c, input logic [2:0] rm, input logic [2:0] rn,
                             input logic [2:0] rd, input logic [15:0] imm, input logic [2:0] u);
    in_t x;
    x.ctrl = c; x.rm = rm; x.rn = rn; x.rd = rd; x.imm = imm; x.used = u;
    return x;
  endfunction

  function automatic out_t as_out(input in_t x);
    out_t o;
    o.valid = 1'b1;
    o.p     = x;
    return o;
  endfunction

  function automatic row_t mk_row(input logic v, input logic st, input logic fl, input in_t x,
                                  input logic h, input logic r, input out_t e);
    row_t rw;
    rw.v = v; rw.st = st; rw.fl = fl; rw.in = x;
    rw.exp_haz = h; rw.exp_rdy = r; rw.exp = e;
    return rw;
  endfunction

  function automatic out_t got_out();
    return (sel == 1) ? obs1 : obs2;
  endfunction

  function automatic logic [1:0] got_hr();
    return (sel == 1) ? {haz1, rdy1} : {haz2, rdy2};
  endfunction

  function automatic logic got_loads();
    return (sel == 1) ? loads1 : loads2;
  endfunction

  task automatic drive(input row_t r);
    in_valid   = r.v;
    stall_dn   = r.st;
    flush      = r.fl;
    control_in = r.in.ctrl;
    num_Rm_in  = r.in.rm;
    num_Rn_in  = r.in.rn;
    num_Rd_in  = r.in.rd;
    imm_in     = r.in.imm;
    used_in    = r.in.used;
  endtask

  task automatic do_reset();
    drive('0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  // Instruction library
  in_t ia, ib, ic, l4, l4n, d4, l5, i7, d5, x5;
  initial begin
    ia  = mk(22'h000005, 3'd1, 3'd2, 3'd3, 16'h1234, 3'b111);
    ib  = mk(22'h3FFFFF, 3'd7, 3'd7, 3'd7, 16'hFFFF, 3'b011);
    ic  = mk(22'h000020, 3'd7, 3'd0, 3'd0, 16'h0001, 3'b001);
    l4  = mk(22'h000100, 3'd0, 3'd0, 3'd4, 16'h0000, 3'b100);
    l4n = mk(22'h000100, 3'd0, 3'd0, 3'd4, 16'h0000, 3'b000);
    d4  = mk(22'h000001, 3'd4, 3'd0, 3'd6, 16'h00AA, 3'b101);
    l5  = mk(22'h000100, 3'd0, 3'd0, 3'd5, 16'h0000, 3'b100);
    i7  = mk(22'h000002, 3'd1, 3'd2, 3'd7, 16'h0011, 3'b011);
    d5  = mk(22'h000003, 3'd0, 3'd5, 3'd1, 16'h0022, 3'b010);
    x5  = mk(22'h000004, 3'd5, 3'd5, 3'd5, 16'h0033, 3'b100);
  end

  task automatic test_reset();
    drive('0);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs1 !== BUBBLE || loads1 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ls1 outputs: got %h expected %h", obs1, BUBBLE);
    end
    checks++;
    if (obs2 !== BUBBLE || loads2 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ls2 outputs: got %h expected %h", obs2, BUBBLE);
    end
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if ({haz1, rdy1, haz2, rdy2} !== 4'b0101) begin
      errors++; $display("[TB] FAIL reset_release hazard/ready: got %b expected 0101", {haz1, rdy1, haz2, rdy2});
    end
    stall_dn = 1'b1;
    #1;
    checks++;
    if ({rdy1, rdy2} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_stall in_ready: got %b expected 00", {rdy1, rdy2});
    end
    stall_dn = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    row_t rows[$];
    out_t e;
    sel = 2;
    do_reset();
    rows.push_back(mk_row(1, 0, 0, ia, 0, 1, as_out(ia)));
    rows.push_back(mk_row(1, 0, 0, ib, 0, 1, as_out(ib)));
    rows.push_back(mk_row(1, 0, 0, ic, 0, 1, as_out(ic)));
    rows.push_back(mk_row(0, 0, 0, ia, 0, 1, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, ia, 0, 1, as_out(ia)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      checks++;
      if (got_hr() !== {rows[i].exp_haz, rows[i].exp_rdy}) begin
        errors++; $display("[TB] FAIL basic row %0d hazard/ready: got %b expected %b", i, got_hr(), {rows[i].exp_haz, rows[i].exp_rdy});
      end
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (got_out() !== e || got_loads() !== e.p.ctrl[8]) begin
        errors++; $display("[TB] FAIL basic row %0d output: got %h/%b expected %h/%b", i, got_out(), got_loads(), e, e.p.ctrl[8]);
      end
    end
  endtask

  task automatic test_load_use_ls1();
    row_t rows[$];
    out_t e;
    sel = 1;
    do_reset();
    rows.push_back(mk_row(1, 0, 0, l4,  0, 1, as_out(l4)));
    rows.push_back(mk_row(1, 0, 0, d4,  1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d4,  0, 1, as_out(d4)));
    rows.push_back(mk_row(1, 0, 0, l4n, 0, 1, as_out(l4n)));
    rows.push_back(mk_row(1, 0, 0, d4,  0, 1, as_out(d4)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      checks++;
      if (got_hr() !== {rows[i].exp_haz, rows[i].exp_rdy}) begin
        errors++; $display("[TB] FAIL ls1 row %0d hazard/ready: got %b expected %b", i, got_hr(), {rows[i].exp_haz, rows[i].exp_rdy});
      end
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (got_out() !== e || got_loads() !== e.p.ctrl[8]) begin
        errors++; $display("[TB] FAIL ls1 row %0d output: got %h/%b expected %h/%b", i, got_out(), got_loads(), e, e.p.ctrl[8]);
      end
    end
  endtask

  task automatic test_load_use_ls2();
    row_t rows[$];
    out_t e;
    sel = 2;
    do_reset();
    rows.push_back(mk_row(1, 0, 0, l5, 0, 1, as_out(l5)));
    rows.push_back(mk_row(1, 0, 0, i7, 0, 1, as_out(i7)));
    rows.push_back(mk_row(1, 0, 0, d5, 1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d5, 0, 1, as_out(d5)));
    rows.push_back(mk_row(1, 0, 0, l5, 0, 1, as_out(l5)));
    rows.push_back(mk_row(1, 0, 0, d5, 1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d5, 1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d5, 0, 1, as_out(d5)));
    rows.push_back(mk_row(1, 0, 0, l5, 0, 1, as_out(l5)));
    rows.push_back(mk_row(1, 0, 0, x5, 0, 1, as_out(x5)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      checks++;
      if (got_hr() !== {rows[i].exp_haz, rows[i].exp_rdy}) begin
        errors++; $display("[TB] FAIL ls2 row %0d hazard/ready: got %b expected %b", i, got_hr(), {rows[i].exp_haz, rows[i].exp_rdy});
      end
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (got_out() !== e || got_loads() !== e.p.ctrl[8]) begin
        errors++; $display("[TB] FAIL ls2 row %0d output: got %h/%b expected %h/%b", i, got_out(), got_loads(), e, e.p.ctrl[8]);
      end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    out_t e;
    sel = 2;
    do_reset();
    rows.push_back(mk_row(1, 0, 0, ia, 0, 1, as_out(ia)));
    for (int k = 0; k < 3; k++) rows.push_back(mk_row(1, 1, 0, ib, 0, 0, as_out(ia)));
    rows.push_back(mk_row(1, 0, 0, ib, 0, 1, as_out(ib)));
    rows.push_back(mk_row(1, 0, 0, l5, 0, 1, as_out(l5)));
    rows.push_back(mk_row(1, 1, 0, d5, 1, 0, as_out(l5)));
    rows.push_back(mk_row(1, 1, 0, d5, 1, 0, as_out(l5)));
    rows.push_back(mk_row(1, 0, 0, d5, 1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d5, 1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d5, 0, 1, as_out(d5)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      checks++;
      if (got_hr() !== {rows[i].exp_haz, rows[i].exp_rdy}) begin
        errors++; $display("[TB] FAIL stall row %0d hazard/ready: got %b expected %b", i, got_hr(), {rows[i].exp_haz, rows[i].exp_rdy});
      end
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (got_out() !== e || got_loads() !== e.p.ctrl[8]) begin
        errors++; $display("[TB] FAIL stall row %0d output: got %h/%b expected %h/%b", i, got_out(), got_loads(), e, e.p.ctrl[8]);
      end
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    out_t e;
    sel = 2;
    do_reset();
    rows.push_back(mk_row(1, 0, 0, ia, 0, 1, as_out(ia)));
    rows.push_back(mk_row(1, 1, 1, ib, 0, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, ib, 0, 1, as_out(ib)));
    rows.push_back(mk_row(1, 0, 0, l5, 0, 1, as_out(l5)));
    rows.push_back(mk_row(1, 0, 1, d5, 1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d5, 1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d5, 0, 1, as_out(d5)));
    rows.push_back(mk_row(1, 0, 0, l5, 0, 1, as_out(l5)));
    rows.push_back(mk_row(0, 0, 0, d5, 0, 1, BUBBLE));
    rows.push_back(mk_row(1, 1, 1, d5, 1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d5, 1, 0, BUBBLE));
    rows.push_back(mk_row(1, 0, 0, d5, 0, 1, as_out(d5)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      checks++;
      if (got_hr() !== {rows[i].exp_haz, rows[i].exp_rdy}) begin
        errors++; $display("[TB] FAIL flush row %0d hazard/ready: got %b expected %b", i, got_hr(), {rows[i].exp_haz, rows[i].exp_rdy});
      end
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (got_out() !== e || got_loads() !== e.p.ctrl[8]) begin
        errors++; $display("[TB] FAIL flush row %0d output: got %h/%b expected %h/%b", i, got_out(), got_loads(), e, e.p.ctrl[8]);
      end
    end
  endtask

  task automatic test_reset_mid_hazard();
    out_t e;
    sel = 2;
    do_reset();
    drive(mk_row(1, 0, 0, l5, 0, 1, as_out(l5)));
    exp_q.push_back(as_out(l5));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs2 !== e) begin
      errors++; $display("[TB] FAIL midrst load: got %h expected %h", obs2, e);
    end
    drive(mk_row(1, 0, 0, d5, 1, 0, BUBBLE));
    #1;
    checks++;
    if ({haz2, rdy2} !== 2'b10) begin
      errors++; $display("[TB] FAIL midrst hazard_before: got %b expected 10", {haz2, rdy2});
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs2 !== BUBBLE || loads2 !== 1'b0 || haz2 !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst async_clear: got %h/%b/%b expected %h/0/0", obs2, loads2, haz2, BUBBLE);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({haz2, rdy2} !== 2'b01) begin
      errors++; $display("[TB] FAIL midrst hazard_after: got %b expected 01", {haz2, rdy2});
    end
    exp_q.push_back(as_out(d5));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs2 !== e) begin
      errors++; $display("[TB] FAIL midrst dependent: got %h expected %h", obs2, e);
    end
    drive('0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2;
    test_reset();
    test_basic();
    test_load_use_ls1();
    test_load_use_ls2();
    test_stall();
    test_flush();
    test_reset_mid_hazard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
